// File: rtl/blk_c0e1da_if.sv
// Handshake bundle for the trace packer: 2-bit entry input, 34-bit frame
// output, flush request/status and the overflow flag.
interface blk_c0e1da_if;
   logic        dct_in_valid;
   logic [1:0]  dct_in_data;
   logic        dct_in_ready;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic        out_valid;
   logic [33:0] out_data;
   logic        out_ready;
   logic        test_ending;
   logic        test_has_ended;
   logic        overflow;

   modport master (
      output dct_in_valid, dct_in_data, out_ready, test_ending,
      input  dct_in_ready, dct_buffer, dct_count, out_valid, out_data,
             test_has_ended, overflow
   );

   modport slave (
      input  dct_in_valid, dct_in_data, out_ready, test_ending,
      output dct_in_ready, dct_buffer, dct_count, out_valid, out_data,
             test_has_ended, overflow
   );
endinterface

// File: rtl/blk_c0e1da.sv
// Packs 2-bit trace entries into 15-slot frames and emits {count, buffer}
// through a single output register; a flush drains any partial frame.
module blk_c0e1da (
   input  logic         clk,
   input  logic         reset_n,
   blk_c0e1da_if.slave  bus
);
   typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_ENDED} state_t;

   state_t      state_q;
   logic [29:0] buffer_q;
   logic [29:0] buffer_d;
   logic [3:0]  count_q;
   logic [3:0]  count_d;
   logic        out_valid_q;
   logic [33:0] out_data_q;
   logic        ended_q;
   logic        overflow_q;

   logic        out_free;
   logic        in_ready;
   logic        accept;
   logic        frame_load;
   logic [3:0]  cnt_base;
   logic [14:0] slot_we;

   // Ready is forced low while reset is held, not just after it.
   assign out_free   = !out_valid_q || bus.out_ready;
   assign in_ready   = reset_n && (state_q == ST_RUN) &&
                       ((count_q != 4'd15) || out_free);
   assign accept     = bus.dct_in_valid && in_ready;
   assign frame_load = out_free &&
                       (((state_q == ST_RUN) && (count_q == 4'd15)) ||
                        ((state_q == ST_FLUSH) && (count_q != 4'd0)));

   // A frame leaving this cycle empties the buffer before the new entry lands.
   assign cnt_base = frame_load ? 4'd0 : count_q;
   assign count_d  = accept ? (cnt_base + 4'd1) : cnt_base;

   genvar gi;
   generate
      for (gi = 0; gi < 15; gi++) begin : g_slot
         assign slot_we[gi] = accept && (cnt_base == 4'(gi));
         assign buffer_d[2*gi+1:2*gi] =
            slot_we[gi] ? bus.dct_in_data :
            (frame_load ? 2'b00 : buffer_q[2*gi+1:2*gi]);
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_RUN;
         buffer_q    <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         ended_q     <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         buffer_q <= buffer_d;
         count_q  <= count_d;

         if (frame_load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= {count_q, buffer_q};
         end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
         end

         case (state_q)
            ST_RUN: begin
               if (bus.dct_in_valid && !in_ready)
                  overflow_q <= 1'b1;
               if (bus.test_ending)
                  state_q <= ST_FLUSH;
            end
            ST_FLUSH: begin
               // Done only once the last partial frame has been taken.
               if ((count_q == 4'd0) && !out_valid_q) begin
                  state_q <= ST_ENDED;
                  ended_q <= 1'b1;
               end
            end
            ST_ENDED: ;
            default: state_q <= ST_RUN;
         endcase
      end
   end

   assign bus.dct_in_ready   = in_ready;
   assign bus.dct_buffer     = buffer_q;
   assign bus.dct_count      = count_q;
   assign bus.out_valid      = out_valid_q;
   assign bus.out_data       = out_data_q;
   assign bus.test_has_ended = ended_q;
   assign bus.overflow       = overflow_q;
endmodule

// File: tb/tb_blk_c0e1da.sv
// Directed bench for the trace packer: a vector table for fill/emit plus
// hand sequences for backpressure, collision, flush and reset.
module tb_blk_c0e1da;
   logic clk;
   logic reset_n;
   int   checks;
   int   errors;

   blk_c0e1da_if bus ();

   blk_c0e1da dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [1:0]  d;
      logic        ordy;
      logic        te;
      logic        x_ready;
      logic [3:0]  x_count;
      logic [29:0] x_buf;
      logic        x_oval;
      logic        x_ovf;
      logic        chk_data;
      logic [33:0] x_data;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] d, input logic ordy, input logic te);
      bus.dct_in_valid = v;
      bus.dct_in_data  = d;
      bus.out_ready    = ordy;
      bus.test_ending  = te;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      drive(1'b0, 2'b00, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic put(input logic [1:0] d, input logic ordy);
      drive(1'b1, d, ordy, 1'b0);
      tick();
   endtask

   function automatic void add(input logic v, input logic [1:0] d, input logic ordy,
                               input logic x_ready, input logic [3:0] x_count,
                               input logic [29:0] x_buf, input logic x_oval,
                               input logic chk_data, input logic [33:0] x_data);
      vec_t t;
      t.v = v; t.d = d; t.ordy = ordy; t.te = 1'b0;
      t.x_ready = x_ready; t.x_count = x_count; t.x_buf = x_buf;
      t.x_oval = x_oval; t.x_ovf = 1'b0; t.chk_data = chk_data; t.x_data = x_data;
      vecs.push_back(t);
   endfunction

   task automatic apply_vec(input int idx, input vec_t t);
      drive(t.v, t.d, t.ordy, t.te);
      chk($sformatf("v%0d ready", idx), 64'(bus.dct_in_ready), 64'(t.x_ready));
      tick();
      chk($sformatf("v%0d count", idx), 64'(bus.dct_count), 64'(t.x_count));
      chk($sformatf("v%0d buffer", idx), 64'(bus.dct_buffer), 64'(t.x_buf));
      chk($sformatf("v%0d out_valid", idx), 64'(bus.out_valid), 64'(t.x_oval));
      chk($sformatf("v%0d overflow", idx), 64'(bus.overflow), 64'(t.x_ovf));
      if (t.chk_data)
         chk($sformatf("v%0d out_data", idx), 64'(bus.out_data), 64'(t.x_data));
      $display("vec %0d: in v=%0b d=%0d ordy=%0b -> count=%0d buf=%h oval=%0b",
               idx, t.v, t.d, t.ordy, bus.dct_count, bus.dct_buffer, bus.out_valid);
   endtask

   initial begin
      logic [29:0] eb;
      checks = 0;
      errors = 0;

      // Table: 1,2,3 then 12 x 3 to a full frame, emit, handshake.
      add(1'b1, 2'd1, 1'b1, 1'b1, 4'd1, 30'h1,  1'b0, 1'b0, '0);
      add(1'b1, 2'd2, 1'b1, 1'b1, 4'd2, 30'h9,  1'b0, 1'b0, '0);
      add(1'b1, 2'd3, 1'b1, 1'b1, 4'd3, 30'h39, 1'b0, 1'b0, '0);
      eb = 30'h39;
      for (int i = 3; i < 15; i++) begin
         eb = eb | (30'h3 << (2 * i));
         add(1'b1, 2'd3, 1'b1, 1'b1, 4'(i + 1), eb, 1'b0, 1'b0, '0);
      end
      add(1'b0, 2'd0, 1'b1, 1'b1, 4'd0, 30'h0, 1'b1, 1'b1, 34'h3_FFFF_FFF9);
      add(1'b1, 2'd3, 1'b1, 1'b1, 4'd1, 30'h3, 1'b0, 1'b1, 34'h3_FFFF_FFF9);

      // Reset state, including ready held low during reset.
      reset_n = 1'b0;
      drive(1'b1, 2'd1, 1'b1, 1'b0);
      chk("reset ready", 64'(bus.dct_in_ready), 64'd0);
      chk("reset count", 64'(bus.dct_count), 64'd0);
      chk("reset out_valid", 64'(bus.out_valid), 64'd0);
      chk("reset out_data", 64'(bus.out_data), 64'd0);
      chk("reset ended", 64'(bus.test_has_ended), 64'd0);
      chk("reset overflow", 64'(bus.overflow), 64'd0);
      do_reset();

      foreach (vecs[i]) apply_vec(i, vecs[i]);

      // Full frame of 2'b11.
      do_reset();
      for (int i = 0; i < 15; i++) put(2'd3, 1'b1);
      chk("full count15", 64'(bus.dct_count), 64'd15);
      chk("full pre oval", 64'(bus.out_valid), 64'd0);
      drive(1'b0, 2'd0, 1'b1, 1'b0);
      tick();
      chk("full out_data", 64'(bus.out_data), 64'h3_FFFF_FFFF);
      chk("full out_valid", 64'(bus.out_valid), 64'd1);
      chk("full count0", 64'(bus.dct_count), 64'd0);
      $display("seq full: out_data=%h", bus.out_data);

      // Backpressure: hold the frame, fill another, drop a 16th entry.
      for (int i = 0; i < 15; i++) put(2'd1, 1'b0);
      chk("bp count15", 64'(bus.dct_count), 64'd15);
      chk("bp held frame", 64'(bus.out_data), 64'h3_FFFF_FFFF);
      drive(1'b1, 2'd2, 1'b0, 1'b0);
      chk("bp ready low", 64'(bus.dct_in_ready), 64'd0);
      tick();
      chk("bp overflow", 64'(bus.overflow), 64'd1);
      chk("bp dropped buf", 64'(bus.dct_buffer), 64'h1555_5555);
      chk("bp dropped count", 64'(bus.dct_count), 64'd15);
      drive(1'b0, 2'd0, 1'b1, 1'b0);
      chk("bp ready free", 64'(bus.dct_in_ready), 64'd1);
      tick();
      chk("bp second frame", 64'(bus.out_data), 64'h3_D555_5555);
      chk("bp second valid", 64'(bus.out_valid), 64'd1);
      chk("bp count0", 64'(bus.dct_count), 64'd0);
      $display("seq backpressure: out_data=%h overflow=%0b", bus.out_data, bus.overflow);

      // Frame emit and entry accept in the same cycle.
      for (int i = 0; i < 15; i++) put(2'd1, 1'b1);
      chk("sim oval before", 64'(bus.out_valid), 64'd0);
      drive(1'b1, 2'd2, 1'b1, 1'b0);
      chk("sim ready", 64'(bus.dct_in_ready), 64'd1);
      tick();
      chk("sim out_data", 64'(bus.out_data), 64'h3_D555_5555);
      chk("sim out_valid", 64'(bus.out_valid), 64'd1);
      chk("sim count1", 64'(bus.dct_count), 64'd1);
      chk("sim buf", 64'(bus.dct_buffer), 64'h2);
      $display("seq simultaneous: count=%0d buf=%h", bus.dct_count, bus.dct_buffer);

      // Flush: fifth entry arrives with the test_ending pulse.
      do_reset();
      for (int i = 0; i < 4; i++) put(2'd1, 1'b0);
      drive(1'b1, 2'd1, 1'b0, 1'b1);
      chk("fl te ready", 64'(bus.dct_in_ready), 64'd1);
      tick();
      chk("fl count5", 64'(bus.dct_count), 64'd5);
      chk("fl buf", 64'(bus.dct_buffer), 64'h155);
      drive(1'b1, 2'd3, 1'b0, 1'b0);
      chk("fl ready low", 64'(bus.dct_in_ready), 64'd0);
      tick();
      chk("fl out_data", 64'(bus.out_data), 64'h1_4000_0155);
      chk("fl out_valid", 64'(bus.out_valid), 64'd1);
      chk("fl count0", 64'(bus.dct_count), 64'd0);
      chk("fl no ovf", 64'(bus.overflow), 64'd0);
      drive(1'b0, 2'd0, 1'b0, 1'b0);
      tick();
      chk("fl held", 64'(bus.out_valid), 64'd1);
      chk("fl not ended", 64'(bus.test_has_ended), 64'd0);
      drive(1'b0, 2'd0, 1'b1, 1'b0);
      tick();
      chk("fl taken", 64'(bus.out_valid), 64'd0);
      tick();
      chk("fl ended", 64'(bus.test_has_ended), 64'd1);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 2'd2, 1'b1, 1'b1);
         chk($sformatf("end%0d ready", i), 64'(bus.dct_in_ready), 64'd0);
         tick();
         chk($sformatf("end%0d count", i), 64'(bus.dct_count), 64'd0);
         chk($sformatf("end%0d ended", i), 64'(bus.test_has_ended), 64'd1);
         chk($sformatf("end%0d oval", i), 64'(bus.out_valid), 64'd0);
      end
      $display("seq flush: out_data=%h ended=%0b", bus.out_data, bus.test_has_ended);

      // Reset while a flushed frame is held.
      do_reset();
      for (int i = 0; i < 3; i++) put(2'd2, 1'b0);
      drive(1'b0, 2'd0, 1'b0, 1'b1);
      tick();
      drive(1'b0, 2'd0, 1'b0, 1'b0);
      tick();
      chk("rst pre oval", 64'(bus.out_valid), 64'd1);
      reset_n = 1'b0;
      #1;
      chk("rst oval", 64'(bus.out_valid), 64'd0);
      chk("rst data", 64'(bus.out_data), 64'd0);
      chk("rst count", 64'(bus.dct_count), 64'd0);
      chk("rst buf", 64'(bus.dct_buffer), 64'd0);
      chk("rst ready", 64'(bus.dct_in_ready), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      drive(1'b1, 2'd2, 1'b0, 1'b0);
      chk("rel ready", 64'(bus.dct_in_ready), 64'd1);
      tick();
      chk("rel count", 64'(bus.dct_count), 64'd1);
      chk("rel buf", 64'(bus.dct_buffer), 64'h2);
      $display("seq reset: count=%0d buf=%h", bus.dct_count, bus.dct_buffer);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
